// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } imem_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_if.sv
// Loader stream and core fetch port bundled as one interface.
interface imem_loader_if #(
    parameter int unsigned AW = 8
);
    logic          ld_start;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [31:0]   pc_out;
    logic [31:0]   instruction;
    logic          core_run;
    logic [AW:0]   ld_count;
    logic          ld_error;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, pc_out,
        input  ld_ready, instruction, core_run, ld_count, ld_error
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, pc_out,
        output ld_ready, instruction, core_run, ld_count, ld_error
    );
endinterface

// File: rtl/imem_loader_ram.sv
// Program storage: synchronous write, asynchronous read, contents never reset.
module imem_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Loads a program word stream into instruction memory, then releases the core
// and serves zero-latency fetches bounded by the loaded program length.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_loader_if.slave   bus
);

    imem_state_t   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          we;
    logic [31:0]   rdata;
    logic          pc_in_range;

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.ld_data),
        .raddr_i (bus.pc_out[AW-1:0]),
        .rdata_o (rdata)
    );

    // Full 32-bit compare, so any PC bit above AW-1 falls out of range.
    assign pc_in_range = (bus.pc_out < {{(31-AW){1'b0}}, count_q});
    assign bus.ld_count = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;
        we              = 1'b0;
        bus.ld_ready    = 1'b0;
        bus.core_run    = 1'b0;
        bus.ld_error    = 1'b0;
        bus.instruction = NOP_WORD;

        unique case (state_q)
            IDLE: ;
            LOAD: begin
                bus.ld_ready = 1'b1;
                if (bus.ld_valid && !bus.ld_start) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + (AW+1)'(1);
                    if (bus.ld_last) begin
                        state_d = RUN;
                    end else if (wr_ptr_q == AW'(DEPTH-1)) begin
                        state_d = ERROR;
                    end
                end
            end
            RUN: begin
                bus.core_run = 1'b1;
                if (pc_in_range) begin
                    bus.instruction = rdata;
                end
            end
            ERROR: begin
                bus.ld_error = 1'b1;
            end
        endcase

        // A restart overrides any beat presented in the same cycle.
        if (bus.ld_start) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            count_d  = '0;
            we       = 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with hand-computed expected values.
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_RET = 6'h08;

    logic clk;
    logic rst_n;
    int unsigned n_cmp;
    int unsigned n_err;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        bus.pc_out = pc;
        #1;
        check_eq(tag, bus.instruction, exp);
    endtask

    initial begin
        logic [31:0] w0, w1, w2;
        w0 = {OP_J,   26'd18};
        w1 = {OP_JAL, 26'd24};
        w2 = {OP_RET, 26'd0};

        n_cmp = 0;
        n_err = 0;
        rst_n        = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        bus.pc_out   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        check_eq("rst_ready", 32'(bus.ld_ready), 32'd0);
        check_eq("rst_run",   32'(bus.core_run), 32'd0);
        check_eq("rst_count", 32'(bus.ld_count), 32'd0);
        check_eq("rst_error", 32'(bus.ld_error), 32'd0);
        check_eq("rst_instr", bus.instruction,   32'h0);

        // Valid beats in IDLE are ignored.
        beat(32'h5555_5555, 1'b1);
        check_eq("idle_count", 32'(bus.ld_count), 32'd0);
        check_eq("idle_ready", 32'(bus.ld_ready), 32'd0);

        // Basic three-word program.
        start_load();
        check_eq("load_ready", 32'(bus.ld_ready), 32'd1);
        check_eq("load_run",   32'(bus.core_run), 32'd0);
        beat(w0, 1'b0);
        beat(w1, 1'b0);
        check_eq("load_cnt2", 32'(bus.ld_count), 32'd2);
        beat(w2, 1'b1);
        check_eq("p1_count", 32'(bus.ld_count), 32'd3);
        check_eq("p1_run",   32'(bus.core_run), 32'd1);
        check_eq("p1_ready", 32'(bus.ld_ready), 32'd0);
        fetch("p1_pc1", 32'd1, w1);
        fetch("p1_pc0", 32'd0, w0);
        fetch("p1_pc2", 32'd2, w2);
        fetch("p1_pc3", 32'd3, 32'h0);

        // Valid gaps: 1,0,0,1,1-last.
        start_load();
        beat(32'hA000_000A, 1'b0);
        bus.ld_data = 32'hFFFF_FFFF;
        tick();
        tick();
        check_eq("gap_count", 32'(bus.ld_count), 32'd1);
        beat(32'hB000_000B, 1'b0);
        beat(32'hC000_000C, 1'b1);
        check_eq("gap_total", 32'(bus.ld_count), 32'd3);
        fetch("gap_pc0", 32'd0, 32'hA000_000A);
        fetch("gap_pc1", 32'd1, 32'hB000_000B);
        fetch("gap_pc2", 32'd2, 32'hC000_000C);
        fetch("gap_pc3", 32'd3, 32'h0);

        // Overflow: DEPTH words without last.
        start_load();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            beat(32'h1000_0000 + 32'(i), 1'b0);
        end
        check_eq("ovf_error", 32'(bus.ld_error), 32'd1);
        check_eq("ovf_run",   32'(bus.core_run), 32'd0);
        check_eq("ovf_ready", 32'(bus.ld_ready), 32'd0);
        check_eq("ovf_instr", bus.instruction,   32'h0);
        beat(32'hBAD0_0000, 1'b0);
        check_eq("ovf_hold",  32'(bus.ld_error), 32'd1);
        check_eq("ovf_word0", dut.u_ram.mem[0],   32'h1000_0000);
        check_eq("ovf_w255",  dut.u_ram.mem[255], 32'h1000_00FF);
        start_load();
        check_eq("ovf_clr_err",   32'(bus.ld_error), 32'd0);
        check_eq("ovf_clr_ready", 32'(bus.ld_ready), 32'd1);
        check_eq("ovf_clr_count", 32'(bus.ld_count), 32'd0);

        // Full-depth program with last on the final word.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            beat(32'h2000_0000 + 32'(i), (i == DEPTH - 1));
        end
        check_eq("full_run",   32'(bus.core_run), 32'd1);
        check_eq("full_count", 32'(bus.ld_count), 32'd256);
        check_eq("full_err",   32'(bus.ld_error), 32'd0);
        fetch("full_pc255", 32'd255,        32'h2000_00FF);
        fetch("full_pc7",   32'd7,          32'h2000_0007);
        fetch("full_pc256", 32'h0000_0100,  32'h0);
        fetch("full_pchi",  32'h8000_0005,  32'h0);

        // Reload from RUN.
        bus.pc_out = 32'd7;
        start_load();
        check_eq("rl_run",   32'(bus.core_run), 32'd0);
        check_eq("rl_count", 32'(bus.ld_count), 32'd0);
        check_eq("rl_instr", bus.instruction,   32'h0);
        beat(32'hDEAD_BEEF, 1'b1);
        check_eq("rl_run2",  32'(bus.core_run), 32'd1);
        check_eq("rl_cnt1",  32'(bus.ld_count), 32'd1);
        fetch("rl_pc0", 32'd0, 32'hDEAD_BEEF);
        fetch("rl_pc1", 32'd1, 32'h0);

        // Restart colliding with a valid beat.
        start_load();
        beat(32'h0000_0011, 1'b0);
        bus.ld_start = 1'b1;
        beat(32'h0000_0022, 1'b1);
        bus.ld_start = 1'b0;
        check_eq("col_count", 32'(bus.ld_count), 32'd0);
        check_eq("col_ready", 32'(bus.ld_ready), 32'd1);
        beat(32'h0000_0033, 1'b1);
        check_eq("col_cnt1", 32'(bus.ld_count), 32'd1);
        fetch("col_pc0", 32'd0, 32'h0000_0033);

        // Reset in the middle of a load.
        bus.pc_out = 32'd0;
        start_load();
        beat(32'h0000_0044, 1'b0);
        beat(32'h0000_0055, 1'b0);
        check_eq("mr_cnt2", 32'(bus.ld_count), 32'd2);
        rst_n = 1'b0;
        tick();
        check_eq("mr_count", 32'(bus.ld_count), 32'd0);
        check_eq("mr_ready", 32'(bus.ld_ready), 32'd0);
        check_eq("mr_run",   32'(bus.core_run), 32'd0);
        check_eq("mr_instr", bus.instruction,   32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("mr_idle", 32'(bus.ld_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters: DEPTH, 256, instruction words held; AW, 8, word-address width (log2 DEPTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ld_start  input  1  one-cycle pulse; begins a (re)load of program memory.
REQ-005 ld_valid  input  1  loader word valid.
REQ-006 ld_data  input  32  loader instruction word.
REQ-007 ld_last  input  1  marks final word of the program; sampled with ld_valid.
REQ-008 ld_ready  output  1  loader may transfer a word this cycle.
REQ-009 pc_out  input  32  core program counter, word index (PC+1 per instruction).
REQ-010 instruction  output  32  instruction word presented to the core.
REQ-011 core_run  output  1  high only when a complete program is loaded; core is held otherwise.
REQ-012 ld_count  output  AW+1  number of words in the loaded program.
REQ-013 ld_error  output  1  overflow: DEPTH words accepted without ld_last.

Function
REQ-014 FSM states IDLE, LOAD, RUN, ERROR; state encoding is a package enum.
REQ-015 IDLE: ld_ready=0, core_run=0; ld_start -> LOAD; ld_valid ignored.
REQ-016 LOAD: ld_ready=1; a beat is accepted when ld_valid && ld_ready; accepted word written to mem[wr_ptr], wr_ptr and ld_count increment by 1 the following edge.
REQ-017 LOAD, accepted beat with ld_last=1 -> RUN next cycle; ld_count includes that word.
REQ-018 LOAD, accepted beat is word DEPTH-1 with ld_last=0 -> ERROR; no wrap-around write to word 0.
REQ-019 LOAD, accepted beat is word DEPTH-1 with ld_last=1 -> RUN, ld_count=DEPTH.
REQ-020 LOAD, ld_valid=0: no write, state held, counters held.
REQ-021 RUN: ld_ready=0, core_run=1; instruction combinationally = mem[pc_out[AW-1:0]] when pc_out < ld_count, else NOP_WORD (zero-latency read; core is single-cycle).
REQ-022 pc_out with any bit above AW-1 set is out of range -> NOP_WORD.
REQ-023 All states except RUN: instruction = NOP_WORD.
REQ-024 ERROR: ld_error=1, ld_ready=0, core_run=0; held until ld_start or reset.
REQ-025 ld_start in LOAD, RUN or ERROR -> LOAD next cycle; wr_ptr, ld_count, ld_error cleared; core_run low from that next cycle; memory contents not cleared.
REQ-026 ld_start together with ld_valid in LOAD: ld_start wins, the beat is not written, pointer restarts at 0.
REQ-027 ld_start in LOAD/IDLE does not count as a beat; ld_ready is registered-state-derived, never combinational on ld_valid.

Reset
REQ-028 rst_n=0 at a clock edge: state=IDLE, wr_ptr=0, ld_count=0, ld_error=0; outputs ld_ready=0, core_run=0, instruction=NOP_WORD.
REQ-029 Reset mid-LOAD or mid-RUN aborts immediately; memory array not reset.

Structure
REQ-030 Package definitions gains: imem_state_t enum (IDLE, LOAD, RUN, ERROR) and NOP_WORD (32'h0000_0000).
REQ-031 One sub-module imem_ram: DEPTH x 32, synchronous write, asynchronous read; FSM and counters stay in imem_loader.

Verification
REQ-032 Reset, ld_start, load 3 words {J,26'd18}, {JAL,26'd24}, {RET,26'd0} with last on word 3 -> ld_count=3, core_run=1; pc_out=1 -> instruction={JAL,26'd24}; pc_out=3 -> NOP_WORD.
REQ-033 Load with ld_valid gaps (valid 1,0,0,1,1-last) -> exactly 3 writes, ld_count=3, no duplicate writes.
REQ-034 Load 256 words, no ld_last -> ld_error=1, core_run=0, word 0 unchanged; ld_start -> ld_error=0, LOAD.
REQ-035 In RUN, ld_start then 1-word load 32'hDEAD_BEEF -> core_run low for load duration, then pc_out=0 gives 32'hDEAD_BEEF, ld_count=1.
REQ-036 rst_n=0 mid-LOAD after 2 beats -> IDLE, ld_count=0, ld_ready=0, instruction=NOP_WORD next cycle.
REQ-037 pc_out=32'h0000_0100 in RUN with ld_count=256 -> NOP_WORD.
